// File: rtl/cfg_stream_pkg.sv
// Shared geometry and FSM encoding for the configuration stream link.
// The transmit and receive ends both import this package, so frame
// geometry is defined in one place.
package cfg_stream_pkg;

  localparam int unsigned CFG_DATA_W  = 32;
  localparam int unsigned CFG_WORDS   = 384;
  localparam int unsigned CFG_FRAME_W = CFG_DATA_W * CFG_WORDS;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } cfg_stream_state_t;

endpackage : cfg_stream_pkg

// File: rtl/cfg_stream_tx.sv
// Transmit end of the configuration stream link.
// On an accepted start, the wide cfg bus is captured into a snapshot register.
// The snapshot is then sent as an AXI4-Stream master, most-significant word
// first, one DATA_W-bit word per accepted beat.
module cfg_stream_tx
  import cfg_stream_pkg::*;
#(
  parameter int unsigned DATA_W = CFG_DATA_W,
  parameter int unsigned WORDS  = CFG_WORDS
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start,
  input  logic [DATA_W*WORDS-1:0]   cfg,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned FRAME_W = DATA_W * WORDS;
  localparam int unsigned CNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

  cfg_stream_state_t state, state_next;

  logic [FRAME_W-1:0] snapshot;
  logic [CNT_W-1:0]   beat_cnt;
  logic               done_q;

  logic last_word;
  logic load_snap;
  logic shift_snap;
  logic frame_end;

  assign last_word = (beat_cnt == LAST_CNT);

  // State register; reset abandons any in-flight frame.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the datapath strobes.
  // A start request arriving while SEND is active is ignored.
  always_comb begin
    state_next = state;
    load_snap  = 1'b0;
    shift_snap = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = SEND;
          load_snap  = 1'b1;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (last_word) begin
            state_next = IDLE;
            frame_end  = 1'b1;
          end else begin
            shift_snap = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Snapshot shift register and beat counter.
  // The top word of the snapshot is always the word being presented,
  // so the snapshot holds while the sink stalls.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      snapshot <= '0;
      beat_cnt <= '0;
    end else if (load_snap) begin
      snapshot <= cfg;
      beat_cnt <= '0;
    end else if (shift_snap) begin
      snapshot <= {snapshot[FRAME_W-DATA_W-1:0], {DATA_W{1'b0}}};
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

  // One-cycle completion pulse after the final beat is accepted.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      done_q <= 1'b0;
    end else begin
      done_q <= frame_end;
    end
  end

  // Stream outputs are decoded from registers only.
  // As a result, tvalid never depends on tready.
  always_comb begin
    m_axis_tdata  = snapshot[FRAME_W-1 -: DATA_W];
    m_axis_tvalid = (state == SEND);
    m_axis_tlast  = (state == SEND) && last_word;
    busy          = (state == SEND);
    done          = done_q;
  end

endmodule : cfg_stream_tx
